min_priority_arbiter: RTL
=========================

# min_priority_arbiter

Four-requester arbiter that shares a single resource by granting the requester with the smallest 3-bit priority value (lower value = more urgent). Sits in front of the shared datapath resource; requesters present `req` plus a priority code, and the block issues a registered one-hot grant held until release or timeout. Arbitration reuses the minimum-of-four selection as a combinational sub-module, masked by active requests, with deterministic tie-breaking.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held (2..255).
- `AGE_PERIOD`, 4: cycles of denied waiting per age increment (used only when aging is compiled in).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset: asynchronous assert, active-low; deassertion synchronous to `clk` upstream.
- `req`  input  4  request per requester, level, held until granted and served.
- `prio0`..`prio3`  input  3 each  priority code per requester; sampled only in the arbitration cycle.
- `gnt`  output  4  one-hot grant, registered.
- `gnt_idx`  output  2  index of granted requester; valid when `gnt_valid`.
- `gnt_valid`  output  1  OR of `gnt`.
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset: state IDLE; `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, hold counter=0, mask=0, age counters=0.
- States: IDLE, GRANT.
- IDLE: candidates = `req` & ~mask. If any candidate, pick min effective priority among candidates; ties -> lowest index. Register grant, clear hold counter, clear mask, go GRANT. If candidates empty but `req` nonzero (only masked requester asking), ignore mask and grant it.
- Non-requesting inputs never win regardless of priority value.
- GRANT: hold counter increments each cycle.
  - `req[gnt_idx]` low -> clear grant, go IDLE.
  - else counter == `MAX_HOLD`-1 -> clear grant, pulse `timeout`, set mask bit of revoked requester, go IDLE.
  - Release and timeout in same cycle: release wins, no `timeout`, no mask.
- Mask is applied to exactly one arbitration, then cleared.
- Priority changes while granted have no effect on the current grant.

## Timing
- Request seen in IDLE at edge N -> `gnt` high after edge N+1 (1-cycle latency).
- Release: `req` low sampled at edge M -> `gnt` low after M; earliest next grant after M+1 (one idle cycle between grants, always).
- Timeout: grant holds exactly `MAX_HOLD` cycles; `timeout` high in the first cycle `gnt` is low.
- `rst_n` low mid-grant: all outputs 0 immediately (asynchronous), no `timeout` pulse.

## Configuration
- `MIN_ARB_AGING_EN` defined: per-requester 3-bit age counter; increments (saturating at 7) every `AGE_PERIOD` cycles while requesting and not granted; cleared when granted or `req` drops. Effective priority = max(prio − age, 0), 3-bit saturating subtract.
- Not defined: no age counters; effective priority = raw `prio`. `AGE_PERIOD` unused.

## Structure
- Package `min_arb_pkg`: state enum (IDLE, GRANT), `PRIO_W`=3, `N_REQ`=4, `IDX_W`=2.
- Sub-module `min4_idx`: combinational; inputs four 3-bit values plus 4-bit valid mask; outputs 2-bit index of minimum valid value (lowest index on tie) and `any_valid`.
- Top holds FSM, hold counter, mask register, optional age counters.

## Test plan
- Reset: `rst_n`=0 with `req`=4'b1111 -> all outputs 0; after release, first grant one cycle later.
- Priorities 5,3,6,1 all requesting -> `gnt`=4'b1000, `gnt_idx`=3 one cycle after request.
- Tie: prio 2,2,7,7, `req`=4'b0011 -> `gnt_idx`=0; req3 with prio 0 but `req[3]`=0 -> never granted.
- Hold `req[1]` forever with `MAX_HOLD`=4, `req[2]` also pending -> `gnt[1]` for 4 cycles, `timeout` pulse, idle cycle, then `gnt[2]` even though prio1 < prio2.
- Release and timeout on same edge -> `timeout` stays 0, next arbitration unmasked.
- With `MIN_ARB_AGING_EN`, `AGE_PERIOD`=2: req0 prio 6 waiting while req1 prio 3 repeatedly re-requests -> req0 age reaches 3 after 6 denied cycles, effective 3 ties, req0 granted by lower index.

Source files
------------

// File: rtl/min_arb_pkg.sv
// Shared types and sizing for the four-way minimum-priority arbiter.
// Optional aging build: define MIN_ARB_AGING_EN.
package min_arb_pkg;

    localparam int PRIO_W = 3;
    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Floor-at-zero subtract used to turn raw priority plus age into effective priority.
    function automatic logic [PRIO_W-1:0] sat_sub(input logic [PRIO_W-1:0] a,
                                                  input logic [PRIO_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/min4_idx.sv
// Minimum-of-four selector over valid entries; lowest index wins ties.
// Latency: combinational. Backpressure: none.
// Output any_valid is low when no entry is valid (idx is then 0).
module min4_idx
    import min_arb_pkg::*;
(
    input  logic [PRIO_W-1:0] v0,
    input  logic [PRIO_W-1:0] v1,
    input  logic [PRIO_W-1:0] v2,
    input  logic [PRIO_W-1:0] v3,
    input  logic [N_REQ-1:0]  vld,
    output logic [IDX_W-1:0]  idx,
    output logic              any_valid
);

    logic [PRIO_W-1:0] val [N_REQ];
    logic [PRIO_W-1:0] best;

    assign val[0] = v0;
    assign val[1] = v1;
    assign val[2] = v2;
    assign val[3] = v3;

    // Strict less-than keeps the earlier (lower) index on a tie.
    always_comb begin
        idx       = '0;
        best      = '1;
        any_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vld[i] && (!any_valid || (val[i] < best))) begin
                idx       = IDX_W'(i);
                best      = val[i];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/min_priority_arbiter.sv
// Four-requester arbiter: registered one-hot grant to the smallest effective priority.
// Latency: 1 cycle request-to-grant; one idle cycle always separates consecutive grants.
// Backpressure: grant held while req stays high, revoked after MAX_HOLD cycles (MIN_ARB_AGING_EN adds aging).
module min_priority_arbiter
    import min_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int AGE_PERIOD = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [PRIO_W-1:0] prio0,
    input  logic [PRIO_W-1:0] prio1,
    input  logic [PRIO_W-1:0] prio2,
    input  logic [PRIO_W-1:0] prio3,
    output logic [N_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || AGE_PERIOD < 1 || AGE_PERIOD > 255) begin : g_bad_cfg
        $error("min_priority_arbiter: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_d;
    logic [IDX_W-1:0]  idx_d;
    logic              timeout_d;
    logic [7:0]        hold_q, hold_d;
    logic [N_REQ-1:0]  mask_q, mask_d;

    logic [PRIO_W-1:0] prio [N_REQ];
    logic [PRIO_W-1:0] eff  [N_REQ];
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  arb_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;

    assign prio[0] = prio0;
    assign prio[1] = prio1;
    assign prio[2] = prio2;
    assign prio[3] = prio3;

`ifdef MIN_ARB_AGING_EN
    localparam logic [7:0] PER_LAST = 8'(AGE_PERIOD - 1);

    logic [PRIO_W-1:0] age_q [N_REQ];
    logic [7:0]        per_q [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                age_q[i] <= '0;
                per_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    age_q[i] <= '0;
                    per_q[i] <= '0;
                end else if (per_q[i] == PER_LAST) begin
                    per_q[i] <= '0;
                    if (age_q[i] != '1) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                end else begin
                    per_q[i] <= per_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eff[i] = sat_sub(prio[i], age_q[i]);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eff[i] = prio[i];
        end
    end
`endif

    // A lone masked requester is still served rather than leaving the resource idle.
    assign cand    = req & ~mask_q;
    assign arb_vld = (|cand) ? cand : req;

    min4_idx u_min4_idx (
        .v0        (eff[0]),
        .v1        (eff[1]),
        .v2        (eff[2]),
        .v3        (eff[3]),
        .vld       (arb_vld),
        .idx       (win_idx),
        .any_valid (win_any)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        idx_d     = gnt_idx;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        mask_d    = mask_q;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (win_any) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = hold_q + 8'd1;
                if (!req[gnt_idx]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    mask_d    = gnt;
                    state_d   = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            timeout <= 1'b0;
            hold_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            timeout <= timeout_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
        end
    end

    assign gnt_valid = |gnt;

endmodule
